// File: rtl/int_to_fp_pipe.sv
// -----------------------------------------------------------------------------
// int_to_fp_pipe
//   Pipelined 32-bit integer to IEEE-754 single-precision converter. This is the
//   packing side of the FP datapath: it produces {sign, exp[7:0], mant[22:0]}
//   words in the layout the float adder unpacks.
//
//   Stages (one register each, all advancing together on the shared enable):
//     S1  sign extraction, magnitude, zero detect
//     S2  leading-zero count and normalisation shift
//     S3  exponent, mantissa, optional rounding -> out_data register
//
//   Configuration macro:
//     ROUND_NEAREST_EN  defined:   round to nearest, ties to even
//                       undefined: truncate toward zero (matches truncating adder)
//
// Parameters
//   SIGNED_IN   1: in_data is two's complement, 0: unsigned (sign always 0)
//
// Ports
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   in_data is valid this cycle
//   in_ready   out  1   converter accepts in_data this cycle
//   in_data    in   32  integer operand
//   out_valid  out  1   out_data holds a converted result
//   out_ready  in   1   downstream accepts out_data this cycle
//   out_data   out  32  IEEE-754 single {sign, exp, mant}
// -----------------------------------------------------------------------------
module int_to_fp_pipe #(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  // Single pipeline enable: everything moves when the output slot is free or
  // being drained, everything holds otherwise. No bubble collapsing, so the
  // latency is fixed at three edges.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic        s1_valid, s1_sign, s1_zero;
  logic [31:0] s1_mag;

  logic        s2_valid, s2_sign, s2_zero;
  logic [4:0]  s2_lz;
  logic [31:0] s2_norm;

  // ---------------------------------------------------------------------------
  // S1 combinational: sign and magnitude
  // ---------------------------------------------------------------------------
  logic        s1_sign_c;
  logic [31:0] s1_mag_c;

  // Negation is done as unsigned arithmetic, so -2^31 maps to 0x80000000.
  assign s1_sign_c = SIGNED_IN && in_data[31];
  assign s1_mag_c  = s1_sign_c ? (~in_data + 32'd1) : in_data;

  // ---------------------------------------------------------------------------
  // S2 combinational: leading-zero count and normalisation
  // ---------------------------------------------------------------------------
  logic [4:0]  lz_c;
  logic        lz_found;
  logic [31:0] norm_c;

  // NOTE: every variable written in an always_comb gets a default on entry so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lz_c     = 5'd0;
    lz_found = 1'b0;
    // Bit 0 is never scanned: the count saturates at 31, which is the right
    // shift for mag==1 and irrelevant for zero (the zero flag overrides).
    for (int i = 31; i >= 1; i--) begin
      if (!lz_found) begin
        if (s1_mag[i]) lz_found = 1'b1;
        else           lz_c     = lz_c + 5'd1;
      end
    end
  end

  assign norm_c = s1_mag << lz_c;

  // ---------------------------------------------------------------------------
  // S3 combinational: exponent, mantissa, rounding, packing
  // ---------------------------------------------------------------------------
  logic [7:0]  exp_c;
  logic [22:0] mant_c;
  logic [31:0] word_c;

`ifdef ROUND_NEAREST_EN
  logic        guard_c, sticky_c, round_up_c, carry_c;
  logic [22:0] mant_sum_c;

  assign guard_c    = s2_norm[7];
  assign sticky_c   = |s2_norm[6:0];
  assign round_up_c = guard_c && (sticky_c || s2_norm[8]);
  assign {carry_c, mant_sum_c} = {1'b0, s2_norm[30:8]} + {23'd0, round_up_c};

  // A carry out of the mantissa means the value rounded up to the next power
  // of two: the sum is already all zeros, only the exponent needs bumping.
  // Max exponent is 159, so this can never overflow into inf.
  assign mant_c = mant_sum_c;
  assign exp_c  = 8'd158 - {3'd0, s2_lz} + {7'd0, carry_c};
`else
  assign mant_c = s2_norm[30:8];
  assign exp_c  = 8'd158 - {3'd0, s2_lz};
`endif

  // Zero input packs to +0 exactly, never -0 and never a nonzero exponent.
  assign word_c = s2_zero ? 32'h0000_0000 : {s2_sign, exp_c, mant_c};

  // ---------------------------------------------------------------------------
  // Control state: valids and the output word
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 32'h0000_0000;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      out_data  <= word_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: datapath registers carry no reset; their contents are only ever
  // observed qualified by the matching valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign <= s1_sign_c;
      s1_mag  <= s1_mag_c;
      s1_zero <= (in_data == 32'd0);
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_lz   <= lz_c;
      s2_norm <= norm_c;
    end
  end

endmodule
